// File: rtl/msrv32_csr_pkg.sv
// Shared constants and types for the msrv32 machine-mode CSR file.
package msrv32_csr_pkg;

    localparam logic [11:0] CsrMstatus   = 12'h300;
    localparam logic [11:0] CsrMtvec     = 12'h305;
    localparam logic [11:0] CsrMscratch  = 12'h340;
    localparam logic [11:0] CsrMepc      = 12'h341;
    localparam logic [11:0] CsrMcause    = 12'h342;
    localparam logic [11:0] CsrMtval     = 12'h343;
    localparam logic [11:0] CsrMcycle    = 12'hB00;
    localparam logic [11:0] CsrMinstret  = 12'hB02;
    localparam logic [11:0] CsrMcycleh   = 12'hB80;
    localparam logic [11:0] CsrMinstreth = 12'hB82;
    localparam logic [11:0] CsrMvendorid = 12'hF11;
    localparam logic [11:0] CsrMarchid   = 12'hF12;
    localparam logic [11:0] CsrMimpid    = 12'hF13;
    localparam logic [11:0] CsrMhartid   = 12'hF14;

    typedef enum logic [2:0] {
        CsrOpRw  = 3'b001,
        CsrOpRs  = 3'b010,
        CsrOpRc  = 3'b011,
        CsrOpRwi = 3'b101,
        CsrOpRsi = 3'b110,
        CsrOpRci = 3'b111
    } csr_op_e;

    localparam int unsigned MstatusMie  = 3;
    localparam int unsigned MstatusMpie = 7;
    localparam logic [1:0]  MstatusMpp  = 2'b11;

    localparam logic [31:0] CsrResetVal = 32'h0000_0000;
    localparam logic [63:0] CntResetVal = 64'h0;

endpackage

// File: rtl/msrv32_csr_if.sv
// CSR access bus between the write-back stage (master) and the CSR file (slave).
interface msrv32_csr_if;
    import msrv32_csr_pkg::*;

    logic        wr_en_csr_file_in;
    logic [11:0] csr_addr_in;
    logic [2:0]  csr_op_in;
    logic [31:0] rs1_in;
    logic [4:0]  imm_in;
    logic [31:0] csr_data_out;
    logic        illegal_csr_out;

    modport master (
        output wr_en_csr_file_in, csr_addr_in, csr_op_in, rs1_in, imm_in,
        input  csr_data_out, illegal_csr_out
    );

    modport slave (
        input  wr_en_csr_file_in, csr_addr_in, csr_op_in, rs1_in, imm_in,
        output csr_data_out, illegal_csr_out
    );
endinterface

// File: rtl/msrv32_csr_counter64.sv
// 64-bit free-running counter; a half-write overrides only that half of the incremented value.
module msrv32_csr_counter64
    import msrv32_csr_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] count_o
);

    logic [63:0] cnt_q, cnt_d, sum;

    always_comb begin
        sum   = cnt_q + {63'b0, inc_i};
        cnt_d = sum;
        if (wr_lo_i) cnt_d[31:0]  = wdata_i;
        if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= CntResetVal;
        else         cnt_q <= cnt_d;
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/msrv32_csr_file.sv
// Machine-mode CSR file: Zicsr read-modify-write, mcycle/minstret, trap entry and mret.
module msrv32_csr_file
    import msrv32_csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic               ms_riscv32_mp_clk_in,
    input  logic               ms_riscv32_mp_rst_in,
    msrv32_csr_if.slave        csr_bus,
    input  logic               trap_taken_in,
    input  logic [4:0]         cause_in,
    input  logic [31:0]        pc_in,
    input  logic [31:0]        tval_in,
    input  logic               mret_in,
    input  logic               instret_inc_in,
    output logic [31:0]        trap_address_out,
    output logic [31:0]        epc_out,
    output logic               mie_out
);

    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d, mtval_q, mtval_d;
    logic [63:0] mcycle, minstret;
    logic [31:0] rdata, src, wval;
    logic        mapped, read_only, op_ok, wr_ok;
    csr_op_e     op;

    assign op  = csr_op_e'(csr_bus.csr_op_in);
    assign src = csr_bus.csr_op_in[2] ? {27'b0, csr_bus.imm_in} : csr_bus.rs1_in;

    always_comb begin
        rdata     = '0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (csr_bus.csr_addr_in)
            CsrMstatus: begin
                rdata[MstatusMie]  = mie_q;
                rdata[MstatusMpie] = mpie_q;
                rdata[12:11]       = MstatusMpp;
            end
            CsrMtvec:     rdata = mtvec_q;
            CsrMscratch:  rdata = mscratch_q;
            CsrMepc:      rdata = mepc_q;
            CsrMcause:    rdata = mcause_q;
            CsrMtval:     rdata = mtval_q;
            CsrMcycle:    rdata = mcycle[31:0];
            CsrMcycleh:   rdata = mcycle[63:32];
            CsrMinstret:  rdata = minstret[31:0];
            CsrMinstreth: rdata = minstret[63:32];
            CsrMvendorid, CsrMarchid, CsrMimpid: read_only = 1'b1;
            CsrMhartid: begin
                rdata     = HART_ID;
                read_only = 1'b1;
            end
            default: mapped = 1'b0;
        endcase
    end

    always_comb begin
        wval  = src;
        op_ok = 1'b1;
        case (op)
            CsrOpRw, CsrOpRwi: wval = src;
            CsrOpRs, CsrOpRsi: wval = rdata | src;
            CsrOpRc, CsrOpRci: wval = rdata & ~src;
            default:           op_ok = 1'b0;
        endcase
    end

    assign wr_ok = csr_bus.wr_en_csr_file_in & mapped & ~read_only & op_ok;
    assign csr_bus.csr_data_out    = rdata;
    assign csr_bus.illegal_csr_out = ~mapped |
                                     (csr_bus.wr_en_csr_file_in & (read_only | ~op_ok));

    // Trap/mret assignments come last so they win over a CSR write to the same register.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        if (wr_ok) begin
            case (csr_bus.csr_addr_in)
                CsrMstatus: begin
                    mie_d  = wval[MstatusMie];
                    mpie_d = wval[MstatusMpie];
                end
                CsrMtvec:    mtvec_d    = wval & ~32'h3;
                CsrMscratch: mscratch_d = wval;
                CsrMepc:     mepc_d     = wval & ~32'h3;
                CsrMcause:   mcause_d   = wval;
                CsrMtval:    mtval_d    = wval;
                default: ;
            endcase
        end
        if (trap_taken_in) begin
            mepc_d   = pc_in & ~32'h3;
            mcause_d = {cause_in[4], 27'b0, cause_in[3:0]};
            mtval_d  = tval_in;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_in) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ~32'h3;
            mscratch_q <= CsrResetVal;
            mepc_q     <= CsrResetVal;
            mcause_q   <= CsrResetVal;
            mtval_q    <= CsrResetVal;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
        end
    end

    msrv32_csr_counter64 u_mcycle (
        .clk_i   (ms_riscv32_mp_clk_in),
        .rst_ni  (ms_riscv32_mp_rst_in),
        .inc_i   (1'b1),
        .wr_lo_i (wr_ok && csr_bus.csr_addr_in == CsrMcycle),
        .wr_hi_i (wr_ok && csr_bus.csr_addr_in == CsrMcycleh),
        .wdata_i (wval),
        .count_o (mcycle)
    );

    msrv32_csr_counter64 u_minstret (
        .clk_i   (ms_riscv32_mp_clk_in),
        .rst_ni  (ms_riscv32_mp_rst_in),
        .inc_i   (instret_inc_in),
        .wr_lo_i (wr_ok && csr_bus.csr_addr_in == CsrMinstret),
        .wr_hi_i (wr_ok && csr_bus.csr_addr_in == CsrMinstreth),
        .wdata_i (wval),
        .count_o (minstret)
    );

    assign trap_address_out = {mtvec_q[31:2], 2'b00};
    assign epc_out          = mepc_q;
    assign mie_out          = mie_q;

endmodule

// File: tb/tb_msrv32_csr_file.sv
// Randomized bench for msrv32_csr_file against a register-level reference model.
module tb_msrv32_csr_file;

    localparam logic [31:0] MtvecRst = 32'h0000_0100;
    localparam logic [31:0] HartId   = 32'h0000_0005;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trap, mret, iinc;
    logic [4:0]  cause;
    logic [31:0] pc, tval, trap_addr, epc;
    logic        mie_o;
    int          total = 0, bad = 0;
    logic        check_en = 1'b0;

    msrv32_csr_if bus ();

    msrv32_csr_file #(.MTVEC_RESET(MtvecRst), .HART_ID(HartId)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .csr_bus              (bus),
        .trap_taken_in        (trap),
        .cause_in             (cause),
        .pc_in                (pc),
        .tval_in              (tval),
        .mret_in              (mret),
        .instret_inc_in       (iinc),
        .trap_address_out     (trap_addr),
        .epc_out              (epc),
        .mie_out              (mie_o)
    );

    always #10 clk = ~clk;

    // Reference model state
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_scr, m_mepc, m_mcause, m_mtval;
    logic [63:0] m_cyc, m_ins;
    logic        n_mie, n_mpie;
    logic [31:0] n_mtvec, n_scr, n_mepc, n_mcause, n_mtval;
    logic [63:0] n_cyc, n_ins;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a, output logic ok, output logic ro);
        ok = 1'b1;
        ro = (a >= 12'hF11 && a <= 12'hF14);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h340: return m_scr;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hB02: return m_ins[31:0];
            12'hB82: return m_ins[63:32];
            12'hF11, 12'hF12, 12'hF13: return 32'h0;
            12'hF14: return HartId;
            default: begin ok = 1'b0; return 32'h0; end
        endcase
    endfunction

    task automatic m_reset();
        m_mie = 0; m_mpie = 0; m_mtvec = MtvecRst & ~32'h3;
        m_scr = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_cyc = 0; m_ins = 0;
    endtask

    task automatic model_next();
        logic ok, ro;
        logic [31:0] old, s, wv;
        n_mie = m_mie; n_mpie = m_mpie; n_mtvec = m_mtvec; n_scr = m_scr;
        n_mepc = m_mepc; n_mcause = m_mcause; n_mtval = m_mtval;
        n_cyc = m_cyc + 64'd1;
        n_ins = m_ins + (iinc ? 64'd1 : 64'd0);
        old = m_read(bus.csr_addr_in, ok, ro);
        if (bus.wr_en_csr_file_in && ok && !ro && bus.csr_op_in[1:0] != 2'b00) begin
            s  = bus.csr_op_in[2] ? {27'b0, bus.imm_in} : bus.rs1_in;
            wv = (bus.csr_op_in[1:0] == 2'b01) ? s :
                 (bus.csr_op_in[1:0] == 2'b10) ? (old | s) : (old & ~s);
            case (bus.csr_addr_in)
                12'h300: begin n_mie = wv[3]; n_mpie = wv[7]; end
                12'h305: n_mtvec = wv & ~32'h3;
                12'h340: n_scr = wv;
                12'h341: n_mepc = wv & ~32'h3;
                12'h342: n_mcause = wv;
                12'h343: n_mtval = wv;
                12'hB00: n_cyc[31:0] = wv;
                12'hB80: n_cyc[63:32] = wv;
                12'hB02: n_ins[31:0] = wv;
                12'hB82: n_ins[63:32] = wv;
                default: ;
            endcase
        end
        if (trap) begin
            n_mepc = pc & ~32'h3;
            n_mcause = (cause[4] ? 32'h8000_0000 : 32'h0) + 32'(cause[3:0]);
            n_mtval = tval;
            n_mpie = m_mie;
            n_mie = 1'b0;
        end else if (mret) begin
            n_mie = m_mpie;
            n_mpie = 1'b1;
        end
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        if (!rst_n) m_reset();
        else begin
            m_mie = n_mie; m_mpie = n_mpie; m_mtvec = n_mtvec; m_scr = n_scr;
            m_mepc = n_mepc; m_mcause = n_mcause; m_mtval = n_mtval;
            m_cyc = n_cyc; m_ins = n_ins;
        end
    endtask

    task automatic drive(input logic we, input logic [11:0] a, input logic [2:0] op,
                         input logic [31:0] r, input logic [4:0] im);
        bus.wr_en_csr_file_in = we; bus.csr_addr_in = a; bus.csr_op_in = op;
        bus.rs1_in = r; bus.imm_in = im;
    endtask

    task automatic side(input logic tr, input logic mr, input logic [31:0] p,
                        input logic [4:0] c, input logic [31:0] tv);
        trap = tr; mret = mr; pc = p; cause = c; tval = tv;
    endtask

    // Compare every cycle, mid-period, against the model
    always @(negedge clk) begin
        logic ok, ro, ill;
        logic [31:0] ev;
        if (check_en) begin
            ev  = m_read(bus.csr_addr_in, ok, ro);
            ill = !ok || (bus.wr_en_csr_file_in && (ro || bus.csr_op_in[1:0] == 2'b00));
            chk("csr_data", bus.csr_data_out, ev);
            chk("illegal", {31'b0, bus.illegal_csr_out}, {31'b0, ill});
            chk("trap_addr", trap_addr, {m_mtvec[31:2], 2'b00});
            chk("epc", epc, m_mepc);
            chk("mie", {31'b0, mie_o}, {31'b0, m_mie});
        end
    end

    logic [11:0] addrs [16];

    initial begin
        addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'hB00, 12'hB80,
                  12'hB02, 12'hB82, 12'hF11, 12'hF13, 12'hF14, 12'h7C0, 12'hC00, 12'h340};
        drive(0, 12'h300, 3'b000, 0, 0);
        side(0, 0, 0, 0, 0);
        iinc = 0;
        m_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_en = 1'b1;

        // Reset values and mcycle start
        #2 chk("rst_mstatus", bus.csr_data_out, 32'h0000_1800);
        tick(); drive(0, 12'h305, 3'b000, 0, 0);
        #2 chk("rst_mtvec", bus.csr_data_out, 32'h0000_0100);
        tick(); drive(0, 12'hB00, 3'b000, 0, 0);
        #2 chk("mcycle_start", bus.csr_data_out, 32'd2);
        tick();

        // mscratch RW / RSI / RC
        drive(1, 12'h340, 3'b001, 32'hDEAD_BEEF, 0); tick();
        drive(1, 12'h340, 3'b110, 0, 5'h10);
        #2 chk("scr_rw", bus.csr_data_out, 32'hDEAD_BEEF);
        tick(); drive(1, 12'h340, 3'b011, 32'h0000_000F, 0);
        #2 chk("scr_rs", bus.csr_data_out, 32'hDEAD_BEFF);
        tick(); drive(0, 12'h340, 3'b000, 0, 0);
        #2 chk("scr_rc", bus.csr_data_out, 32'hDEAD_BEF0);
        tick();

        // MIE set, trap entry, mret
        drive(1, 12'h300, 3'b110, 0, 5'd8); tick();
        drive(0, 12'h300, 3'b000, 0, 0); side(1, 0, 32'h200, 5'h0B, 0); tick();
        side(0, 0, 0, 0, 0);
        #2 chk("trap_mstatus", bus.csr_data_out, 32'h0000_1880);
        chk("trap_mepc", epc, 32'h200);
        tick(); drive(0, 12'h342, 3'b000, 0, 0);
        #2 chk("trap_mcause", bus.csr_data_out, 32'h0000_000B);
        tick(); drive(0, 12'h300, 3'b000, 0, 0); side(0, 1, 0, 0, 0); tick();
        side(0, 0, 0, 0, 0);
        #2 chk("mret_mstatus", bus.csr_data_out, 32'h0000_1888);
        chk("mret_mie", {31'b0, mie_o}, 32'd1);
        tick();

        // mcycle carry from a low-half write
        drive(1, 12'hB80, 3'b001, 0, 0); tick();
        drive(1, 12'hB00, 3'b001, 32'hFFFF_FFFF, 0); tick();
        drive(0, 12'hB00, 3'b000, 0, 0);
        #2 chk("cyc_lo_wr", bus.csr_data_out, 32'hFFFF_FFFF);
        tick();
        #2 chk("cyc_lo_wrap", bus.csr_data_out, 32'h0);
        tick(); drive(0, 12'hB80, 3'b000, 0, 0);
        #2 chk("cyc_hi_carry", bus.csr_data_out, 32'h1);
        tick();

        // Read-only and unmapped
        drive(1, 12'hF14, 3'b001, 32'h1234_5678, 0);
        #2 chk("hart_wr_ill", {31'b0, bus.illegal_csr_out}, 32'd1);
        tick(); drive(0, 12'hF14, 3'b000, 0, 0);
        #2 chk("hart_keep", bus.csr_data_out, HartId);
        tick(); drive(0, 12'h7C0, 3'b000, 0, 0);
        #2 chk("unmapped_ill", {31'b0, bus.illegal_csr_out}, 32'd1);
        tick();

        // Trap beats mret and a write to mepc; mscratch write alongside a trap commits
        drive(1, 12'h341, 3'b001, 32'h1234_5678, 0); side(1, 1, 32'h305, 5'h13, 32'hAA); tick();
        drive(0, 12'h342, 3'b000, 0, 0); side(0, 0, 0, 0, 0);
        #2 chk("prio_mepc", epc, 32'h304);
        chk("prio_mie", {31'b0, mie_o}, 32'd0);
        chk("prio_mcause", bus.csr_data_out, 32'h8000_0003);
        tick();
        drive(1, 12'h340, 3'b001, 32'hCAFE_F00D, 0); side(1, 0, 32'h400, 5'h2, 0); tick();
        drive(0, 12'h340, 3'b000, 0, 0); side(0, 0, 0, 0, 0);
        #2 chk("trap_scr_commit", bus.csr_data_out, 32'hCAFE_F00D);
        tick();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            drive(1'($urandom_range(0, 1)), addrs[$urandom_range(0, 15)],
                  3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)));
            side($urandom_range(0, 11) == 0, $urandom_range(0, 7) == 0, $urandom,
                 5'($urandom_range(0, 31)), $urandom);
            iinc = 1'($urandom_range(0, 1));
            tick();
        end
        side(0, 0, 0, 0, 0);
        iinc = 0;

        // Asynchronous reset mid-count
        drive(1, 12'hB80, 3'b001, 0, 0); tick();
        drive(1, 12'hB00, 3'b001, 32'd1000, 0); tick();
        drive(0, 12'hB00, 3'b000, 0, 0);
        #2 chk("cyc_1000", bus.csr_data_out, 32'd1000);
        #1 rst_n = 1'b0;
        m_reset();
        #1 chk("async_cyc", bus.csr_data_out, 32'h0);
        chk("async_epc", epc, 32'h0);
        chk("async_tvec", trap_addr, 32'h100);
        chk("async_mie", {31'b0, mie_o}, 32'd0);
        drive(0, 12'h300, 3'b000, 0, 0);
        #1 chk("async_mstatus", bus.csr_data_out, 32'h0000_1800);
        drive(1, 12'h340, 3'b001, 32'h5555_5555, 0);
        tick(); tick();
        rst_n = 1'b1;
        drive(0, 12'h340, 3'b000, 0, 0);
        #2 chk("rst_drop_wr", bus.csr_data_out, 32'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(0, addrs[i + 4], 3'b000, 0, 0);
            iinc = 1'b1;
            tick();
        end

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
